// File: rtl/maze_pkg.sv
// Shared constants, wall maps and tile lookup for the maze move checker.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned GRID_COLS = 40;
    localparam int unsigned GRID_ROWS = 30;

    // Row masks: bit c set means column c of that row is a wall tile.
    localparam logic [39:0] ROW_FULL = 40'hFF_FFFF_FFFF;
    localparam logic [39:0] ROW_EDGE = 40'h80_0000_0001;
    // Edge walls plus bars at cols 2-5, 16-23 and 34-37; cols 11-13 stay open.
    localparam logic [39:0] ROW_BARS = 40'hBC_00FF_003D;

    localparam logic [39:0] BORDER_MAP [0:29] = '{
        ROW_FULL, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE,
        ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE,
        ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE,
        ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE,
        ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_FULL
    };

    // Rows 8-10 are edge-only so the ghost spawn tile (12,9) and its neighbours stay open.
    localparam logic [39:0] MAZE_MAP [0:29] = '{
        ROW_FULL, ROW_EDGE, ROW_BARS, ROW_EDGE, ROW_BARS, ROW_EDGE,
        ROW_BARS, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_EDGE, ROW_BARS,
        ROW_EDGE, ROW_BARS, ROW_EDGE, ROW_BARS, ROW_EDGE, ROW_BARS,
        ROW_EDGE, ROW_BARS, ROW_EDGE, ROW_BARS, ROW_EDGE, ROW_BARS,
        ROW_EDGE, ROW_BARS, ROW_EDGE, ROW_BARS, ROW_EDGE, ROW_FULL
    };

    // Tiles outside the grid read as open; the out-of-bounds flag covers them.
    function automatic logic is_wall(input logic sel, input logic [5:0] col,
                                     input logic [4:0] row);
        if (row >= 5'(GRID_ROWS) || col >= 6'(GRID_COLS)) begin
            return 1'b0;
        end
        if (sel) begin
            return MAZE_MAP[row][col];
        end
        return BORDER_MAP[row][col];
    endfunction

endpackage

// File: rtl/clk_counter.sv
// Free-running 32-bit cycle counter used as a clock-divider tap source.
module clk_counter (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] clkdiv
);

    logic [31:0] count_q;

    // Count every cycle, wrapping naturally; cleared by synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_q + 32'd1;
        end
    end

    assign clkdiv = count_q;

endmodule

// File: rtl/maze_move_checker.sv
// Two-stage check of whether a one-pixel sprite step hits a wall or leaves the screen.
module maze_move_checker
    import maze_pkg::*;
#(
    parameter int unsigned SPRITE   = 16,
    parameter int unsigned TILE     = 16,
    parameter int unsigned MAZE_SEL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  PacX,
    input  logic [8:0]  PacY,
    input  logic [1:0]  state,
    output logic        result,
    output logic [31:0] clkdiv
);

    localparam int unsigned     TILE_SHIFT = $clog2(TILE);
    localparam logic signed [10:0] S_M1    = 11'(SPRITE - 1);
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - 1);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - 1);
    localparam logic            SEL        = (MAZE_SEL != 0);

    logic signed [10:0] nx, ny, ex, ey;
    logic signed [10:0] pax, pay, pbx, pby;
    logic               oob_d;
    logic [5:0]         col_a_d, col_b_d;
    logic [4:0]         row_a_d, row_b_d;

    logic               valid_q, oob_q, result_q;
    logic [5:0]         col_a_q, col_b_q;
    logic [4:0]         row_a_q, row_b_q;
    logic               result_d;

    clk_counter u_clk_counter (
        .clk    (clk),
        .rst    (rst),
        .clkdiv (clkdiv)
    );

    // Candidate position, bounds test and leading-edge probe tiles.
    always_comb begin
        nx = $signed({1'b0, PacX});
        ny = $signed({2'b00, PacY});
        unique case (dir_e'(state))
            DIR_UP:    ny = ny - 11'sd1;
            DIR_DOWN:  ny = ny + 11'sd1;
            DIR_LEFT:  nx = nx - 11'sd1;
            DIR_RIGHT: nx = nx + 11'sd1;
        endcase
        ex = nx + S_M1;
        ey = ny + S_M1;
        oob_d = (nx < 11'sd0) || (ny < 11'sd0) || (ex > X_MAX) || (ey > Y_MAX);

        pax = nx;
        pay = ny;
        pbx = ex;
        pby = ny;
        unique case (dir_e'(state))
            DIR_UP: begin
                pax = nx; pay = ny; pbx = ex; pby = ny;
            end
            DIR_DOWN: begin
                pax = nx; pay = ey; pbx = ex; pby = ey;
            end
            DIR_LEFT: begin
                pax = nx; pay = ny; pbx = nx; pby = ey;
            end
            DIR_RIGHT: begin
                pax = ex; pay = ny; pbx = ex; pby = ey;
            end
        endcase

        col_a_d = 6'($unsigned(pax) >> TILE_SHIFT);
        row_a_d = 5'($unsigned(pay) >> TILE_SHIFT);
        col_b_d = 6'($unsigned(pbx) >> TILE_SHIFT);
        row_b_d = 5'($unsigned(pby) >> TILE_SHIFT);
        // Park probes on tile (0,0) when out of bounds so nothing off-grid is looked up.
        if (oob_d) begin
            col_a_d = '0;
            row_a_d = '0;
            col_b_d = '0;
            row_b_d = '0;
        end
    end

    // Stage 1: register probe tiles, bounds flag and a valid marker.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            oob_q   <= 1'b0;
            col_a_q <= '0;
            row_a_q <= '0;
            col_b_q <= '0;
            row_b_q <= '0;
        end else begin
            valid_q <= 1'b1;
            oob_q   <= oob_d;
            col_a_q <= col_a_d;
            row_a_q <= row_a_d;
            col_b_q <= col_b_d;
            row_b_q <= row_b_d;
        end
    end

    // Wall lookup for both probes; the valid marker keeps result low after reset.
    always_comb begin
        result_d = valid_q && !oob_q &&
                   !is_wall(SEL, col_a_q, row_a_q) && !is_wall(SEL, col_b_q, row_b_q);
    end

    // Stage 2: register the verdict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q <= 1'b0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_maze_move_checker.sv
// Self-checking bench: directed cases plus random moves against a pixel-level model.
module tb_maze_move_checker;
    import maze_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  pac_x = 10'd200;
    logic [8:0]  pac_y = 9'd146;
    logic [1:0]  dir = 2'b00;
    logic        res0, res1;
    logic [31:0] div0, div1;

    int checks = 0;
    int failures = 0;
    int unsigned edge_cnt = 0;

    bit exp0_q[$];
    bit exp1_q[$];

    always #5 clk = ~clk;

    // Independent cycle count since the last reset release.
    always @(posedge clk) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    maze_move_checker #(.SPRITE(16), .TILE(16), .MAZE_SEL(0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .PacX   (pac_x),
        .PacY   (pac_y),
        .state  (dir),
        .result (res0),
        .clkdiv (div0)
    );

    maze_move_checker #(.SPRITE(16), .TILE(16), .MAZE_SEL(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .PacX   (pac_x),
        .PacY   (pac_y),
        .state  (dir),
        .result (res1),
        .clkdiv (div1)
    );

    function automatic bit tile_wall(bit sel, int c, int r);
        if (sel) return MAZE_MAP[r][c];
        return (c == 0) || (c == 39) || (r == 0) || (r == 29);
    endfunction

    // Step legal iff the moved sprite is on screen and no pixel of its leading edge is in a wall.
    function automatic bit model(bit sel, int x, int y, int d);
        int nx = x;
        int ny = y;
        int px, py;
        case (d)
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
        endcase
        if (nx < 0 || ny < 0 || nx + 15 > 639 || ny + 15 > 479) return 1'b0;
        for (int k = 0; k < 16; k++) begin
            case (d)
                0: begin px = nx + k;  py = ny;      end
                1: begin px = nx + k;  py = ny + 15; end
                2: begin px = nx;      py = ny + k;  end
                default: begin px = nx + 15; py = ny + k; end
            endcase
            if (tile_wall(sel, px / 16, py / 16)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Hold inputs, wait two edges, compare both maze variants against explicit values.
    task automatic directed(input string tag, input int x, input int y, input int d,
                            input bit want0, input bit want1, input bit check1);
        @(negedge clk);
        pac_x = 10'(x);
        pac_y = 9'(y);
        dir   = 2'(d);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(tag, {31'd0, res0}, {31'd0, want0});
        if (check1) chk({tag, "_maze"}, {31'd0, res1}, {31'd0, want1});
    endtask

    // Drive one input set at a negedge; compare outputs for the set driven two negedges ago.
    task automatic stream(input string tag, input int x, input int y, input int d);
        @(negedge clk);
        if (exp0_q.size() >= 2) begin
            chk(tag, {31'd0, res0}, {31'd0, exp0_q.pop_front()});
            chk({tag, "_maze"}, {31'd0, res1}, {31'd0, exp1_q.pop_front()});
        end
        pac_x = 10'(x);
        pac_y = 9'(y);
        dir   = 2'(d);
        exp0_q.push_back(model(1'b0, x, y, d));
        exp1_q.push_back(model(1'b1, x, y, d));
    endtask

    initial begin
        // Reset held for three edges.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", {31'd0, res0}, 32'd0);
        chk("reset_clkdiv", div0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("clkdiv_1", div0, 32'd1);
        chk("post_reset_result", {31'd0, res0}, 32'd0);
        @(posedge clk); #1;
        chk("clkdiv_2", div0, 32'd2);
        @(posedge clk); #1;
        chk("clkdiv_3", div0, 32'd3);

        // Directed cases from the block's documented behaviour.
        directed("free_up",      200, 146, 0, 1'b1, 1'b1, 1'b1);
        directed("wall_left",    16,  146, 2, 1'b0, 1'b0, 1'b0);
        directed("open_left",    17,  146, 2, 1'b1, 1'b0, 1'b0);
        directed("wall_right",   608, 100, 3, 1'b0, 1'b0, 1'b0);
        directed("wall_down",    100, 448, 1, 1'b0, 1'b0, 1'b0);
        directed("open_down",    100, 447, 1, 1'b1, 1'b0, 1'b0);
        directed("oob_up",       0,   0,   0, 1'b0, 1'b0, 1'b1);
        directed("oob_right",    624, 464, 3, 1'b0, 1'b0, 1'b1);

        // Back-to-back inputs alternate blocked/legal.
        for (int i = 0; i < 6; i++) begin
            stream("pipe_alt", (i % 2 == 0) ? 16 : 17, 146, 2);
        end

        // Reset mid-stream clears the result on the next edge and drops in-flight samples.
        @(negedge clk);
        pac_x = 10'd200; pac_y = 9'd146; dir = 2'b00;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_reset_result", {31'd0, res0}, 32'd0);
        chk("mid_reset_result_maze", {31'd0, res1}, 32'd0);
        chk("mid_reset_clkdiv", div0, 32'd0);
        exp0_q.delete();
        exp1_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_release_result", {31'd0, res0}, 32'd0);

        // Random moves, some pinned near the screen edges.
        for (int i = 0; i < 400; i++) begin
            int x, y, d;
            x = $urandom_range(639);
            y = $urandom_range(479);
            d = $urandom_range(3);
            case ($urandom_range(7))
                0: x = $urandom_range(2);
                1: x = 624 - $urandom_range(2);
                2: y = $urandom_range(2);
                3: y = 464 - $urandom_range(2);
                default: ;
            endcase
            stream("rand", x, y, d);
        end
        stream("rand_drain", 200, 146, 0);
        stream("rand_drain", 200, 146, 0);

        @(negedge clk);
        chk("clkdiv_count", div0, edge_cnt);
        chk("clkdiv_count_maze", div1, edge_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
